// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the ALU stage, the result FIFO and its consumer.
// The producer/consumer side uses the master modport; the FIFO uses slave.
interface alu_result_fifo_if #(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 8,
    parameter int DROP_W = 8
);
    logic                     In_Valid;
    logic                     In_Ready;
    logic [WIDTH-1:0]         In_Result;
    logic                     In_Equal;
    logic                     Out_Valid;
    logic                     Out_Ready;
    logic [WIDTH-1:0]         Out_Result;
    logic                     Out_Equal;
    logic [$clog2(DEPTH):0]   Count;
    logic [DROP_W-1:0]        Drop_Count;

    modport master (
        output In_Valid, In_Result, In_Equal, Out_Ready,
        input  In_Ready, Out_Valid, Out_Result, Out_Equal, Count, Drop_Count
    );

    modport slave (
        input  In_Valid, In_Result, In_Equal, Out_Ready,
        output In_Ready, Out_Valid, Out_Result, Out_Equal, Count, Drop_Count
    );
endinterface

// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO that captures {Equal, Result} pairs from the
// combinational ALU. The ALU cannot stall, so pushes refused while full are
// counted in a saturating drop counter instead of being back-pressured.
module alu_result_fifo #(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 8,
    parameter int DROP_W = 8
) (
    input logic              Clock,
    input logic              Reset_n,
    input logic              Clear,
    alu_result_fifo_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]     FULL_COUNT = CW'(DEPTH);
    localparam logic [DROP_W-1:0] DROP_MAX   = {DROP_W{1'b1}};

    logic [WIDTH:0]      mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic [DROP_W-1:0]   drop_count;
    logic [WIDTH:0]      head;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic                drop;

    // Saturating increment: the drop counter sticks at all-ones.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == DROP_MAX) ? v : v + 1'b1;
    endfunction

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // Clear overrides every other action in its cycle, including drops.
    assign push = bus.In_Valid && !full && !Clear;
    assign pop  = bus.Out_Ready && !empty && !Clear;
    assign drop = bus.In_Valid && full && !Clear;

    // Write pointer advances on each accepted entry.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
        end else if (Clear) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // Read pointer advances when the consumer takes the head entry.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_ptr <= '0;
        end else if (Clear) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (Clear) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Count ALU results refused because the buffer was full.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            drop_count <= '0;
        end else if (Clear) begin
            drop_count <= '0;
        end else if (drop) begin
            drop_count <= sat_inc(drop_count);
        end
    end

    // Storage is not reset; occupancy alone decides which entries are live.
    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr] <= {bus.In_Equal, bus.In_Result};
        end
    end

    // Head is read straight from storage, so a new entry shows one cycle
    // after its push edge and never bypasses an empty buffer.
    assign head = empty ? '0 : mem[rd_ptr];

    assign bus.In_Ready   = !full;
    assign bus.Out_Valid  = !empty;
    assign bus.Out_Equal  = head[WIDTH];
    assign bus.Out_Result = head[WIDTH-1:0];
    assign bus.Count      = count;
    assign bus.Drop_Count = drop_count;
endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: a queue model of the FIFO predicts every output
// each cycle, and a table of per-cycle vectors carries hand-derived
// occupancy and drop values for the main scenarios.
module tb_alu_result_fifo;
    localparam int DEPTH  = 4;
    localparam int WIDTH  = 8;
    localparam int DROP_W = 8;

    typedef struct {
        logic       v;
        logic [7:0] r;
        logic       e;
        logic       ordy;
        logic       clr;
        int         exp_count;
        int         exp_drop;
        string      name;
    } vec_t;

    logic Clock;
    logic Reset_n;
    logic Clear;

    alu_result_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DROP_W(DROP_W)) bus ();

    alu_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DROP_W(DROP_W)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Clear   (Clear),
        .bus     (bus)
    );

    int         n_vec = 0;
    int         n_bad = 0;
    logic [8:0] q[$];
    int         drop_m = 0;
    vec_t       vecs[$];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "/out_valid"}, int'(bus.Out_Valid), (q.size() != 0) ? 1 : 0);
        check({tag, "/in_ready"},  int'(bus.In_Ready), (q.size() != DEPTH) ? 1 : 0);
        check({tag, "/count"},     int'(bus.Count), q.size());
        check({tag, "/drop"},      int'(bus.Drop_Count), drop_m);
        check({tag, "/head"},      int'({bus.Out_Equal, bus.Out_Result}),
              (q.size() != 0) ? int'(q[0]) : 0);
    endtask

    // One clock cycle: starts and ends on a falling edge.
    task automatic step(input logic v, input logic [7:0] r, input logic e,
                        input logic ordy, input logic clr, input string tag);
        logic do_push;
        logic do_pop;
        logic do_drop;
        check_outputs(tag);
        bus.In_Valid  = v;
        bus.In_Result = r;
        bus.In_Equal  = e;
        bus.Out_Ready = ordy;
        Clear         = clr;
        do_push = !clr && v && (q.size() != DEPTH);
        do_pop  = !clr && ordy && (q.size() != 0);
        do_drop = !clr && v && (q.size() == DEPTH);
        @(posedge Clock);
        if (clr) begin
            q.delete();
            drop_m = 0;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back({e, r});
            if (do_drop && drop_m < (1 << DROP_W) - 1) drop_m++;
        end
        @(negedge Clock);
        bus.In_Valid  = 1'b0;
        bus.Out_Ready = 1'b0;
        Clear         = 1'b0;
    endtask

    function automatic void add(input logic v, input logic [7:0] r, input logic e,
                                input logic ordy, input logic clr,
                                input int ec, input int ed, input string name);
        vec_t t;
        t.v = v; t.r = r; t.e = e; t.ordy = ordy; t.clr = clr;
        t.exp_count = ec; t.exp_drop = ed; t.name = name;
        vecs.push_back(t);
    endfunction

    initial begin
        // Vector table: stimulus per cycle and occupancy/drops after its edge.
        add(1, 8'h03, 0, 0, 0, 1, 0, "pass_push");
        add(0, 8'h00, 0, 1, 0, 0, 0, "pass_pop");
        add(1, 8'h01, 0, 0, 0, 1, 0, "fill1");
        add(1, 8'h02, 0, 0, 0, 2, 0, "fill2");
        add(1, 8'h03, 0, 0, 0, 3, 0, "fill3");
        add(1, 8'h04, 0, 0, 0, 4, 0, "fill4");
        add(1, 8'hAA, 0, 0, 0, 4, 1, "drop1");
        add(1, 8'hBB, 1, 0, 0, 4, 2, "drop2");
        add(1, 8'hCC, 0, 0, 0, 4, 3, "drop3");
        add(0, 8'h00, 0, 1, 0, 3, 3, "drain1");
        add(0, 8'h00, 0, 1, 0, 2, 3, "drain2");
        add(0, 8'h00, 0, 1, 0, 1, 3, "drain3");
        add(0, 8'h00, 0, 1, 0, 0, 3, "drain4");
        add(0, 8'h00, 0, 1, 1, 0, 0, "clear_idle");
        for (int i = 0; i < 10; i++)
            add(1, 8'h10 + 8'(i), 0, 1, 0, 1, 0, $sformatf("stream%0d", i));
        add(0, 8'h00, 0, 1, 0, 0, 0, "stream_end");
        add(1, 8'h00, 1, 0, 0, 1, 0, "sub_eq");
        add(1, 8'h06, 0, 0, 0, 2, 0, "mul");
        add(0, 8'h00, 0, 1, 0, 1, 0, "pop_sub");
        add(0, 8'h00, 0, 1, 0, 0, 0, "pop_mul");

        Reset_n       = 1'b0;
        Clear         = 1'b0;
        bus.In_Valid  = 1'b0;
        bus.In_Result = '0;
        bus.In_Equal  = 1'b0;
        bus.Out_Ready = 1'b0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset_n = 1'b1;
        @(negedge Clock);
        check("reset/out_valid", int'(bus.Out_Valid), 0);
        check("reset/in_ready", int'(bus.In_Ready), 1);
        check("reset/count", int'(bus.Count), 0);
        check("reset/drop", int'(bus.Drop_Count), 0);
        check("reset/out_result", int'(bus.Out_Result), 0);

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].r, vecs[i].e, vecs[i].ordy, vecs[i].clr, vecs[i].name);
            check({vecs[i].name, "/tbl_count"}, int'(bus.Count), vecs[i].exp_count);
            check({vecs[i].name, "/tbl_drop"}, int'(bus.Drop_Count), vecs[i].exp_drop);
        end
        check_outputs("after_table");

        // Drop counter saturation while full.
        for (int i = 0; i < 4; i++)
            step(1, 8'h40 + 8'(i), 1'(i), 0, 0, "sat_fill");
        for (int i = 0; i < 260; i++)
            step(1, 8'hEE, 0, 0, 0, "sat_hold");
        check("sat/drop", int'(bus.Drop_Count), 255);
        step(0, 8'h00, 0, 1, 0, "sat_pop");
        check("sat/count", int'(bus.Count), 3);

        // Clear beats push, pop and drop in the same cycle.
        step(1, 8'h77, 1, 1, 1, "clear_prio");
        check("clear/count", int'(bus.Count), 0);
        check("clear/drop", int'(bus.Drop_Count), 0);
        check("clear/out_valid", int'(bus.Out_Valid), 0);

        // Asynchronous reset mid-cycle with two live entries.
        step(1, 8'h21, 0, 0, 0, "refill1");
        step(1, 8'h22, 1, 0, 0, "refill2");
        check("refill/count", int'(bus.Count), 2);
        #2;
        Reset_n = 1'b0;
        #1;
        check("async/out_valid", int'(bus.Out_Valid), 0);
        check("async/count", int'(bus.Count), 0);
        check("async/in_ready", int'(bus.In_Ready), 1);
        check("async/head", int'({bus.Out_Equal, bus.Out_Result}), 0);
        q.delete();
        drop_m = 0;
        @(negedge Clock);
        Reset_n = 1'b1;
        step(1, 8'h5A, 1, 0, 0, "post_reset_push");
        check("post_reset/head", int'({bus.Out_Equal, bus.Out_Result}), 9'h15A);
        step(0, 8'h00, 0, 1, 0, "post_reset_pop");
        check_outputs("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream consumer of the ALU stage.
- Captures each valid {Equal, Result} pair the ALU produces into a small first-word-fall-through FIFO.
- Presents captured results to the next consumer (checker, writeback, display) over a valid/ready handshake.
- Counts results lost because the FIFO was full, since the combinational ALU cannot hold its output.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, minimum 2.
WIDTH, 8, width of the Result field; matches the ALU 8-bit Result.
DROP_W, 8, width of the saturating drop counter.

Ports:
Clock  input  1  single system clock; all state updates on rising edge.
Reset_n  input  1  asynchronous, active-low reset.
Clear  input  1  synchronous flush of FIFO contents and drop counter.
In_Valid  input  1  ALU Result/Equal are meaningful this cycle.
In_Ready  output  1  FIFO can accept an entry this cycle.
In_Result  input  WIDTH  ALU Result.
In_Equal  input  1  ALU Equal flag.
Out_Valid  output  1  head entry is available.
Out_Ready  input  1  downstream accepts the head entry this cycle.
Out_Result  output  WIDTH  Result field of the head entry.
Out_Equal  output  1  Equal field of the head entry.
Count  output  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.
Drop_Count  output  DROP_W  saturating count of rejected In_Valid cycles.

Behaviour:
- Storage and pointers:
  - Circular buffer of DEPTH entries, each {Equal, Result}, WIDTH+1 bits.
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Count is a separate register.
- Reset (Reset_n low, asynchronous):
  - Pointers, Count and Drop_Count go to 0.
  - Out_Valid = 0, Out_Result = 0, Out_Equal = 0, In_Ready = 1.
  - Storage contents need not be reset.
- In_Ready = (Count != DEPTH).
- Out_Valid = (Count != 0).
- Out_Result/Out_Equal:
  - Driven from the entry at the read pointer.
  - Forced to 0 when Count = 0.
- Push: In_Valid && In_Ready at a rising edge.
  - Entry is written at the write pointer; write pointer increments.
- Pop: Out_Valid && Out_Ready at a rising edge.
  - Read pointer increments.
- Latency:
  - A pushed entry appears on Out_* in the cycle after the push edge; no combinational input-to-output path.
  - An empty FIFO does not bypass.
- Simultaneous push and pop:
  - Both occur and Count is unchanged.
  - When full, In_Ready is already 0, so no push occurs even if a pop happens that cycle.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Drop:
  - Every rising edge with In_Valid = 1 and In_Ready = 0 increments Drop_Count.
  - Drop_Count saturates at 2^DROP_W - 1 and never wraps.
  - The dropped data is discarded.
- Clear (synchronous):
  - Pointers, Count and Drop_Count go to 0 at the edge.
  - Clear has priority over push, pop and drop in the same cycle.
  - In_Valid data presented in a Clear cycle is discarded and not counted.
- Out_Ready with Out_Valid = 0 has no effect.
- In_Valid = 0 ignores In_Result/In_Equal, including X values.
- Reset asserted mid-stream: all state is lost immediately; the first entry accepted after release is the next head.
- Ordering: strict FIFO; entries are never reordered, duplicated or overwritten while occupied.

Test Plan:
- Reset then idle:
  - Reset_n low 2 cycles, release.
  - Required: Out_Valid=0, In_Ready=1, Count=0, Drop_Count=0, Out_Result=0.
- Single pass-through:
  - Push {Equal=0, Result=8'h03} (ADD 1+2) with Out_Ready=0.
  - Required: next cycle Out_Valid=1, Out_Result=8'h03, Count=1.
  - Assert Out_Ready 1 cycle; required: Count=0, Out_Valid=0.
- Fill and drop:
  - Push 8'h01,8'h02,8'h03,8'h04, then hold In_Valid 3 more cycles with Out_Ready=0.
  - Required: Count=4, In_Ready=0, Drop_Count=3.
  - Pop order is 01,02,03,04.
- Wrap-around with concurrent push/pop:
  - Stream 10 results 8'h10..8'h19 with In_Valid and Out_Ready held high.
  - Required: Count stays at 1 after the first push, outputs are 10..19 in order, Drop_Count=0.
- Equal flag and SUB/MUL results:
  - Push {1,8'h00} (SUB 4-4) then {0,8'h06} (MUL 2*3).
  - Required: Out_Equal=1/Out_Result=00, then Out_Equal=0/Out_Result=06.
- Clear priority and async reset:
  - With Count=3, assert Clear together with In_Valid and Out_Ready; required: Count=0, Drop_Count=0 next cycle.
  - Refill 2 entries, pulse Reset_n low mid-cycle; required: Out_Valid drops to 0 immediately without a clock edge.
